y_serial_adder: RTL and testbench

Parametrised bit-serial adder/subtractor: one full-adder cell, one operand bit per clock, LSB first. It processes two W-bit operands in W cycles under a start/busy/done handshake. It returns the W-bit sum or difference, carry-out and signed overflow. It replaces the combinational 1-bit adder cell wherever area matters more than latency, and serves as the arithmetic primitive for the upcoming multi-cycle datapath.

---
 rtl/y_serial_adder.sv | 90 +++++++++
 tb/tb_y_serial_adder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/y_serial_adder.sv
// rtl/y_serial_adder.sv - bit-serial adder/subtractor, one full-adder cell, LSB first
module y_serial_adder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] z,
  output logic         cout,
  output logic         ovf
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  r_sh;
  logic          carry;
  logic [CW-1:0] cnt;

  logic          s_bit;
  logic          c_next;
  logic [W-1:0]  r_next;

  always_comb begin
    s_bit  = a_sh[0] ^ b_sh[0] ^ carry;
    c_next = (a_sh[0] & b_sh[0]) | ((a_sh[0] ^ b_sh[0]) & carry);
    r_next = {s_bit, r_sh[W-1:1]};
  end

  // Result bits accumulate in r_sh; z is only loaded once the last bit is in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      z     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub;
            r_sh  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          r_sh  <= r_next;
          carry <= c_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB here
            z     <= r_next;
            cout  <= c_next;
            ovf   <= carry ^ c_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_y_serial_adder.sv
// tb/tb_y_serial_adder.sv - self-checking bench for y_serial_adder at W=8, 4, 2 and 32
module tb_y_serial_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  start_v = '0;
  logic [3:0]  sub_v = '0;
  logic [31:0] a_v [4];
  logic [31:0] b_v [4];
  logic [3:0]  busy_v, done_v, cout_v, ovf_v;
  logic [7:0]  z8;
  logic [3:0]  z4;
  logic [1:0]  z2;
  logic [31:0] z32;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  y_serial_adder #(.W(8)) u_w8 (
    .clk(clk), .reset(rst), .start(start_v[0]), .a(a_v[0][7:0]), .b(b_v[0][7:0]),
    .sub(sub_v[0]), .busy(busy_v[0]), .done(done_v[0]), .z(z8), .cout(cout_v[0]), .ovf(ovf_v[0]));
  y_serial_adder #(.W(4)) u_w4 (
    .clk(clk), .reset(rst), .start(start_v[1]), .a(a_v[1][3:0]), .b(b_v[1][3:0]),
    .sub(sub_v[1]), .busy(busy_v[1]), .done(done_v[1]), .z(z4), .cout(cout_v[1]), .ovf(ovf_v[1]));
  y_serial_adder #(.W(2)) u_w2 (
    .clk(clk), .reset(rst), .start(start_v[2]), .a(a_v[2][1:0]), .b(b_v[2][1:0]),
    .sub(sub_v[2]), .busy(busy_v[2]), .done(done_v[2]), .z(z2), .cout(cout_v[2]), .ovf(ovf_v[2]));
  y_serial_adder #(.W(32)) u_w32 (
    .clk(clk), .reset(rst), .start(start_v[3]), .a(a_v[3]), .b(b_v[3]),
    .sub(sub_v[3]), .busy(busy_v[3]), .done(done_v[3]), .z(z32), .cout(cout_v[3]), .ovf(ovf_v[3]));

  function automatic int wid(input int k);
    case (k)
      0: return 8;
      1: return 4;
      2: return 2;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] zval(input int k);
    case (k)
      0: return {24'b0, z8};
      1: return {28'b0, z4};
      2: return {30'b0, z2};
      default: return z32;
    endcase
  endfunction

  // Reference: plain integer arithmetic and a signed range check.
  function automatic void model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                input logic s, output logic [31:0] ez, output logic ec,
                                output logic ev);
    longint m    = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint ua   = longint'({32'b0, av}) & m;
    longint ub   = longint'({32'b0, bv}) & m;
    longint sa   = (ua >= half) ? ua - 2 * half : ua;
    longint sb   = (ub >= half) ? ub - 2 * half : ub;
    longint r    = s ? sa - sb : sa + sb;
    longint full = s ? ua + (~ub & m) + 1 : ua + ub;
    ez = 32'((s ? ua - ub : ua + ub) & m);
    ec = ((full >> w) & 1) != 0;
    ev = (r < -half) || (r > half - 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                        input logic s, input string tag);
    logic [31:0] ez;
    logic        ec, ev;
    int          lat = 0;
    int          bcnt = 0;
    bit          both = 0;
    bit          seen = 0;
    model(wid(k), av, bv, s, ez, ec, ev);
    @(negedge clk);
    a_v[k] = av; b_v[k] = bv; sub_v[k] = s; start_v[k] = 1'b1;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      start_v[k] = 1'b0;
      lat++;
      if (busy_v[k]) bcnt++;
      if (busy_v[k] && done_v[k]) both = 1;
      if (done_v[k]) seen = 1;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_latency"}, 64'(lat - 1), 64'(wid(k)));
    chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(wid(k)));
    chk({tag, "_busy_done_excl"}, 64'(both), 64'd0);
    chk({tag, "_z"}, 64'(zval(k)), 64'(ez));
    chk({tag, "_cout"}, 64'(cout_v[k]), 64'(ec));
    chk({tag, "_ovf"}, 64'(ovf_v[k]), 64'(ev));
    @(negedge clk);
    chk({tag, "_done_single"}, 64'(done_v[k]), 64'd0);
  endtask

  initial begin
    int          pulses;
    int          n2;
    bit          seen;
    logic [31:0] zgot;
    logic [31:0] corner [4];
    for (int k = 0; k < 4; k++) begin a_v[k] = '0; b_v[k] = '0; end

    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy_v), 64'd0);
    chk("rst_done", 64'(done_v), 64'd0);
    chk("rst_z8", 64'(z8), 64'd0);
    chk("rst_cout_ovf", 64'({cout_v, ovf_v}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(busy_v), 64'd0);

    run_op(0, 3, 5, 0, "add_3_5");
    chk("add_3_5_const", 64'(z8), 64'd8);
    run_op(0, 200, 100, 0, "add_200_100");
    chk("add_200_100_const", 64'({z8, cout_v[0], ovf_v[0]}), 64'({8'd44, 2'b10}));
    run_op(0, 8'h7F, 1, 0, "add_7f_1");
    chk("add_7f_1_const", 64'({z8, cout_v[0], ovf_v[0]}), 64'({8'h80, 2'b01}));
    run_op(0, 5, 7, 1, "sub_5_7");
    run_op(0, 9, 9, 1, "sub_9_9");
    run_op(0, 8'h80, 1, 1, "sub_80_1");
    chk("sub_80_1_const", 64'({z8, cout_v[0], ovf_v[0]}), 64'({8'h7F, 2'b11}));

    // start pulsed mid-RUN must not disturb the operation in flight
    @(negedge clk);
    a_v[0] = 1; b_v[0] = 2; sub_v[0] = 0; start_v[0] = 1'b1;
    pulses = 0; zgot = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_v[0]) begin pulses++; zgot = zval(0); end
      start_v[0] = (i == 2);
      if (i == 2) a_v[0] = 50;
    end
    start_v[0] = 1'b0;
    chk("midrun_pulses", 64'(pulses), 64'd1);
    chk("midrun_z", 64'(zgot), 64'd3);

    // start held high through done: back-to-back accept
    @(negedge clk);
    a_v[0] = 3; b_v[0] = 4; sub_v[0] = 0; start_v[0] = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done_v[0]) seen = 1;
    end
    chk("b2b_first_done", 64'(seen), 64'd1);
    chk("b2b_first_z", 64'(z8), 64'd7);
    a_v[0] = 10; b_v[0] = 20;
    seen = 0; n2 = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      n2++;
      if (done_v[0]) seen = 1;
    end
    start_v[0] = 1'b0;
    chk("b2b_second_done", 64'(seen), 64'd1);
    chk("b2b_second_gap", 64'(n2), 64'd9);
    chk("b2b_second_z", 64'(z8), 64'd30);

    run_op(0, 8'h80, 1, 1, "pre_reset");
    // reset three cycles into RUN: outputs clear without a clock edge
    @(negedge clk);
    a_v[0] = 10; b_v[0] = 20; sub_v[0] = 0; start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy_v[0]), 64'd0);
    chk("arst_done", 64'(done_v[0]), 64'd0);
    chk("arst_z", 64'(z8), 64'd0);
    chk("arst_cout", 64'(cout_v[0]), 64'd0);
    chk("arst_ovf", 64'(ovf_v[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done_v[0]) pulses++;
    end
    chk("arst_no_done", 64'(pulses), 64'd0);
    chk("arst_z_held", 64'(z8), 64'd0);
    run_op(0, 100, 27, 1, "post_reset");

    for (int i = 0; i < 30; i++)
      run_op(0, $urandom & 32'hFF, $urandom & 32'hFF, 1'($urandom), "w8_rand");

    for (int av = 0; av < 16; av++)
      for (int bv = 0; bv < 16; bv++)
        for (int s = 0; s < 2; s++)
          run_op(1, 32'(av), 32'(bv), 1'(s), "w4_exh");

    corner[0] = 32'd0; corner[1] = 32'd1; corner[2] = 32'hFFFF_FFFF; corner[3] = 32'h8000_0000;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        run_op(2, corner[i] & 32'h3 | (i == 3 ? 32'h2 : 32'h0),
               corner[j] & 32'h3 | (j == 3 ? 32'h2 : 32'h0), 0, "w2_corner");
        run_op(3, corner[i], corner[j], 0, "w32_corner");
      end
    for (int i = 0; i < 20; i++)
      run_op(3, $urandom, $urandom, 1'($urandom), "w32_rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
